// File: rtl/alarm_timer_pkg.sv
// Shared types and defaults for the alarm countdown timer.
// Interval codes, timer state encoding, duration width and default table.
package alarm_timer_pkg;

  localparam int TIME_W = 4;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [1:0] {
    INT_ARM_DELAY = 2'd0,
    INT_DRIVER    = 2'd1,
    INT_PASSENGER = 2'd2,
    INT_ALARM_ON  = 2'd3
  } interval_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } timer_state_e;

  localparam int DEF_ARM_DELAY       = 6;
  localparam int DEF_DRIVER_DELAY    = 8;
  localparam int DEF_PASSENGER_DELAY = 15;
  localparam int DEF_ALARM_ON        = 10;

endpackage

// File: rtl/alarm_timer_one_hz_divider.sv
// Clock divider producing a 1-cycle tick every TICK_CYCLES clocks.
// A synchronous clear restarts the period from zero.
module one_hz_divider #(
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Period counter; wraps at LAST, restarts on clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (clear || cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/alarm_timer.sv
// Countdown timer for the alarm FSM with a reprogrammable duration table.
// Define ALARM_TIMER_COUNT_OUT_EN to expose the remaining count as time_left.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int TICK_CYCLES       = 50_000_000,
  parameter int T_ARM_DELAY       = DEF_ARM_DELAY,
  parameter int T_DRIVER_DELAY    = DEF_DRIVER_DELAY,
  parameter int T_PASSENGER_DELAY = DEF_PASSENGER_DELAY,
  parameter int T_ALARM_ON        = DEF_ALARM_ON
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_timer,
  input  logic [1:0]  interval,
  input  logic        reprogram,
  input  logic [1:0]  time_param_sel,
  input  logic [TIME_W-1:0] time_value,
  output logic        expired,
  output logic        one_hz_enable
`ifdef ALARM_TIMER_COUNT_OUT_EN
  ,
  output logic [TIME_W-1:0] time_left
`endif
);

  timer_state_e state_q, state_d;
  time_t        count_q, count_d;
  logic         expired_q, expired_d;
  time_t        table_q [4];
  logic         cd_clear;
  logic         cd_tick;

  one_hz_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_strobe_div (
    .clock(clock),
    .reset(reset),
    .clear(1'b0),
    .tick (one_hz_enable)
  );

  one_hz_divider #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_count_div (
    .clock(clock),
    .reset(reset),
    .clear(cd_clear),
    .tick (cd_tick)
  );

  // Each load restarts the countdown second from zero.
  assign cd_clear = (state_q == S_LOAD);

  // Duration table; reset restores the built-in defaults.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      table_q[0] <= time_t'(T_ARM_DELAY);
      table_q[1] <= time_t'(T_DRIVER_DELAY);
      table_q[2] <= time_t'(T_PASSENGER_DELAY);
      table_q[3] <= time_t'(T_ALARM_ON);
    end else if (reprogram) begin
      table_q[time_param_sel] <= time_value;
    end
  end

  // Timer state, remaining count and expired flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  // Next state: reprogram aborts, start restarts, else count down.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    expired_d = expired_q;
    if (reprogram) begin
      state_d   = S_IDLE;
      expired_d = 1'b0;
    end else if (start_timer) begin
      state_d   = S_LOAD;
      expired_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: expired_d = 1'b0;
        S_LOAD: begin
          count_d = table_q[interval];
          if (table_q[interval] == '0) begin
            state_d   = S_DONE;
            expired_d = 1'b1;
          end else begin
            state_d = S_COUNT;
          end
        end
        S_COUNT: begin
          if (cd_tick) begin
            if (count_q == time_t'(1)) begin
              state_d   = S_DONE;
              expired_d = 1'b1;
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        S_DONE: expired_d = 1'b1;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign expired = expired_q;

`ifdef ALARM_TIMER_COUNT_OUT_EN
  assign time_left =
    (state_q == S_LOAD || state_q == S_COUNT) ?
    count_q : '0;
`endif

endmodule
